// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
package uart_pkg;

  localparam int UART_DATA_BITS              = 8;
  localparam int UART_DEFAULT_CLOCKS_PER_BIT = 5208;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  // ST_PARITY_BIT stays in the encoding so the receiver sees a stable type
  // whichever way the transmitter is built.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START_BIT  = 3'd1,
    ST_DATA_BITS  = 3'd2,
    ST_PARITY_BIT = 3'd3,
    ST_STOP_BIT   = 3'd4,
    ST_DONE       = 3'd5
  } uart_tx_state_t;

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte-level handshake between the RAM-to-UART bridge and the transmitter.
interface uart_transmitter_if;
  import uart_pkg::*;

  logic                      START_TRANSMISSION;
  logic [UART_DATA_BITS-1:0] DATA_TO_TRANSMIT;
  logic                      TX_SERIAL_OUT;
  logic                      TRANSMITTER_BUSY;
  logic                      TRANSMITTED_8_BITS_FLAG;

  modport master (
    output START_TRANSMISSION,
    output DATA_TO_TRANSMIT,
    input  TX_SERIAL_OUT,
    input  TRANSMITTER_BUSY,
    input  TRANSMITTED_8_BITS_FLAG
  );

  modport slave (
    input  START_TRANSMISSION,
    input  DATA_TO_TRANSMIT,
    output TX_SERIAL_OUT,
    output TRANSMITTER_BUSY,
    output TRANSMITTED_8_BITS_FLAG
  );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-cycle counter: counts 0..CLOCKS_PER_BIT-1 and wraps; BIT_DONE marks
// the last cycle of the current bit.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = UART_DEFAULT_CLOCKS_PER_BIT
) (
  input  logic MAIN_CLOCK,
  input  logic RESET,
  input  logic CLEAR,
  output logic BIT_DONE
);

  localparam int             W    = $clog2(CLOCKS_PER_BIT);
  localparam logic [W-1:0]   LAST = W'(CLOCKS_PER_BIT - 1);

  logic [W-1:0] r_count;

  // Free-running count held at zero while cleared, wrapping at the bit end.
  always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
    if (RESET) begin
      r_count <= '0;
    end else if (CLEAR || (r_count == LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign BIT_DONE = (r_count == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: one byte per request, 8N1 LSB first, with a one-cycle
// completion flag for the bridge. Define UART_TX_PARITY_EN for 8E1 frames.
//
// state         | meaning
// --------------+------------------------------------------------
// ST_IDLE       | line high, waiting for START_TRANSMISSION
// ST_START_BIT  | line low for one bit time
// ST_DATA_BITS  | shifting out 8 data bits, LSB first
// ST_PARITY_BIT | even parity bit (UART_TX_PARITY_EN builds only)
// ST_STOP_BIT   | line high for one bit time
// ST_DONE       | single cycle, completion flag high
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = UART_DEFAULT_CLOCKS_PER_BIT
) (
  input  logic                MAIN_CLOCK,
  input  logic                RESET,
  uart_transmitter_if.slave   tx_if
);

  localparam logic [2:0] LAST_BIT_IDX = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t            r_state;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [2:0]                r_bit_idx;
  logic                      r_tx;
  logic                      r_busy;
  logic                      r_flag;
  logic                      w_bit_done;
  logic                      w_clear;
`ifdef UART_TX_PARITY_EN
  logic                      r_parity;
`endif

  // Counter is held at zero outside a frame so every frame starts aligned.
  assign w_clear = (r_state == ST_IDLE) || (r_state == ST_DONE);

  uart_baud_counter #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_baud_counter (
    .MAIN_CLOCK (MAIN_CLOCK),
    .RESET      (RESET),
    .CLEAR      (w_clear),
    .BIT_DONE   (w_bit_done)
  );

  // Frame sequencer; line level, busy and flag are set with each transition.
  always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= UART_IDLE_LEVEL;
      r_busy    <= 1'b0;
      r_flag    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_flag <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tx   <= UART_IDLE_LEVEL;
          r_busy <= 1'b0;
          if (tx_if.START_TRANSMISSION) begin
            r_shift   <= tx_if.DATA_TO_TRANSMIT;
            r_bit_idx <= '0;
            r_tx      <= UART_START_LEVEL;
            r_busy    <= 1'b1;
            r_state   <= ST_START_BIT;
`ifdef UART_TX_PARITY_EN
            r_parity  <= ^tx_if.DATA_TO_TRANSMIT;
`endif
          end
        end
        ST_START_BIT: begin
          if (w_bit_done) begin
            r_tx    <= r_shift[0];
            r_state <= ST_DATA_BITS;
          end
        end
        ST_DATA_BITS: begin
          if (w_bit_done) begin
            if (r_bit_idx == LAST_BIT_IDX) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= ST_PARITY_BIT;
`else
              r_tx    <= UART_IDLE_LEVEL;
              r_state <= ST_STOP_BIT;
`endif
            end else begin
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY_BIT: begin
          if (w_bit_done) begin
            r_tx    <= UART_IDLE_LEVEL;
            r_state <= ST_STOP_BIT;
          end
        end
`endif
        ST_STOP_BIT: begin
          if (w_bit_done) begin
            r_flag  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_tx    <= UART_IDLE_LEVEL;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_tx    <= UART_IDLE_LEVEL;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_if.TX_SERIAL_OUT           = r_tx;
  assign tx_if.TRANSMITTER_BUSY        = r_busy;
  assign tx_if.TRANSMITTED_8_BITS_FLAG = r_flag;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with a frame-level scoreboard monitor.
module tb_uart_transmitter;
  import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
  localparam int C  = 2;
  localparam int NB = 11;
`else
  localparam int C  = 4;
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_transmitter_if u_if ();

  uart_transmitter #(
    .CLOCKS_PER_BIT(C)
  ) dut (
    .MAIN_CLOCK (clk),
    .RESET      (rst),
    .tx_if      (u_if)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int flag_count  = 0;
  int start_cyc   = 0;
  int prev_start_cyc = 0;
  int m_phase     = 0;
  int m_pos       = 0;
  logic [10:0] m_bits;
  logic [7:0]  sb_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  // Frame monitor: detects start bits, pops the scoreboard and checks every
  // sampled cycle of the frame plus the DONE cycle and the cycle after it.
  always @(negedge clk) begin
    if (rst) begin
      m_phase = 0;
    end else begin
      if (u_if.TRANSMITTED_8_BITS_FLAG === 1'b1) flag_count++;
      if (m_phase == 0 && u_if.TX_SERIAL_OUT === 1'b0) begin
        prev_start_cyc = start_cyc;
        start_cyc      = cyc;
        check("frame_expected", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) m_bits = frame_bits(sb_q.pop_front());
        else                  m_bits = frame_bits(8'h00);
        m_phase = 1;
        m_pos   = 0;
      end
      if (m_phase == 0) begin
        check("idle_flag", u_if.TRANSMITTED_8_BITS_FLAG, 0);
      end else if (m_phase == 1) begin
        check("frame_bit",
              {u_if.TX_SERIAL_OUT, u_if.TRANSMITTER_BUSY, u_if.TRANSMITTED_8_BITS_FLAG},
              {m_bits[m_pos / C], 1'b1, 1'b0});
        m_pos++;
        if (m_pos == NB * C) m_phase = 2;
      end else if (m_phase == 2) begin
        check("done_cycle",
              {u_if.TX_SERIAL_OUT, u_if.TRANSMITTER_BUSY, u_if.TRANSMITTED_8_BITS_FLAG},
              3'b111);
        m_phase = 3;
      end else begin
        check("after_done",
              {u_if.TX_SERIAL_OUT, u_if.TRANSMITTER_BUSY, u_if.TRANSMITTED_8_BITS_FLAG},
              3'b100);
        m_phase = 0;
      end
    end
  end

  task automatic send(input logic [7:0] b, output int acc);
    @(negedge clk);
    #1;
    u_if.START_TRANSMISSION = 1'b1;
    u_if.DATA_TO_TRANSMIT   = b;
    sb_q.push_back(b);
    @(posedge clk);
    #1;
    acc = cyc;
    u_if.START_TRANSMISSION = 1'b0;
    u_if.DATA_TO_TRANSMIT   = 8'($urandom);
    check("accept_outputs", {u_if.TX_SERIAL_OUT, u_if.TRANSMITTER_BUSY}, 2'b01);
  endtask

  task automatic wait_flag(input string tag, output int fc);
    bit ok;
    ok = 1'b0;
    fc = 0;
    for (int i = 0; i < NB * C + 10; i++) begin
      @(negedge clk);
      if (u_if.TRANSMITTED_8_BITS_FLAG === 1'b1) begin
        ok = 1'b1;
        fc = cyc;
        break;
      end
    end
    check(tag, ok, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, fc, fbase;
    u_if.START_TRANSMISSION = 1'b0;
    u_if.DATA_TO_TRANSMIT   = 8'h00;

    // Reset with no clock edge yet.
    #1 rst = 1'b1;
    #1;
    check("rst_line", u_if.TX_SERIAL_OUT, 1);
    check("rst_busy", u_if.TRANSMITTER_BUSY, 0);
    check("rst_flag", u_if.TRANSMITTED_8_BITS_FLAG, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Single byte 0xA5.
    send(8'hA5, acc);
    wait_flag("a5_flag_seen", fc);
    check("a5_latency", fc - acc, NB * C);
    @(negedge clk);
    check("a5_flag_width", {u_if.TRANSMITTER_BUSY, u_if.TRANSMITTED_8_BITS_FLAG}, 2'b00);
    repeat (4) @(posedge clk);

    // Request while busy is ignored.
    fbase = flag_count;
    send(8'hFF, acc);
    repeat (11) @(posedge clk);
    #1;
    u_if.START_TRANSMISSION = 1'b1;
    u_if.DATA_TO_TRANSMIT   = 8'h3C;
    @(posedge clk);
    #1;
    u_if.START_TRANSMISSION = 1'b0;
    wait_flag("ff_flag_seen", fc);
    check("ff_latency", fc - acc, NB * C);
    repeat (NB * C + 6) @(negedge clk);
    check("ignore_flag_count", flag_count - fbase, 1);
    check("ignore_queue_empty", sb_q.size(), 0);

    // Reset mid-frame.
    fbase = flag_count;
    send(8'h00, acc);
    repeat (18) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_line", u_if.TX_SERIAL_OUT, 1);
    check("midrst_busy", u_if.TRANSMITTER_BUSY, 0);
    check("midrst_flag", u_if.TRANSMITTED_8_BITS_FLAG, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (NB * C) @(negedge clk);
    check("midrst_no_flag", flag_count - fbase, 0);
    send(8'h81, acc);
    wait_flag("x81_flag_seen", fc);
    check("x81_latency", fc - acc, NB * C);
    repeat (4) @(negedge clk);
    check("x81_queue_empty", sb_q.size(), 0);

    // Back-to-back with the request held high.
    fbase = flag_count;
    sb_q.push_back(8'h55);
    sb_q.push_back(8'h55);
    sb_q.push_back(8'h55);
    @(negedge clk);
    #1;
    u_if.START_TRANSMISSION = 1'b1;
    u_if.DATA_TO_TRANSMIT   = 8'h55;
    repeat (2 * (NB * C + 2) + 4) @(posedge clk);
    #1;
    u_if.START_TRANSMISSION = 1'b0;
    repeat (NB * C + 10) @(negedge clk);
    check("b2b_flag_count", flag_count - fbase, 3);
    check("b2b_period", start_cyc - prev_start_cyc, NB * C + 2);
    check("b2b_queue_empty", sb_q.size(), 0);

`ifdef UART_TX_PARITY_EN
    // Even parity: 0x07 -> 1, 0x03 -> 0, parity bit at cycles 18..19.
    send(8'h07, acc);
    repeat (18) @(posedge clk);
    #1;
    check("par07_bit", u_if.TX_SERIAL_OUT, 1);
    wait_flag("par07_flag_seen", fc);
    check("par07_latency", fc - acc, 22);
    repeat (4) @(posedge clk);
    send(8'h03, acc);
    repeat (18) @(posedge clk);
    #1;
    check("par03_bit", u_if.TX_SERIAL_OUT, 0);
    wait_flag("par03_flag_seen", fc);
    check("par03_latency", fc - acc, 22);
`endif

    repeat (5) @(negedge clk);
    check("final_queue_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
